data_mem_mmio: RTL and testbench
================================

Name: data_mem_mmio

Overview:
Data-side memory block directly downstream of the single-cycle core. It consumes MemWrite, ALUResult (address) and WriteData, and returns read_data in the same cycle. Address space is split into word-addressed data RAM and a small MMIO window holding a GPIO output register, a free-running cycle counter and a compare timer with interrupt. All state updates occur on the rising clock edge; reads are combinational so the single-cycle core can load in one cycle.

Parameters:
DEPTH_WORDS, 64, number of 32-bit RAM words; RAM occupies byte addresses 0 .. 4*DEPTH_WORDS-1.
MMIO_BASE, 32'h0000_1000, base byte address of the MMIO window (0x20 bytes, 8 word slots).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
MemWrite  in  1  store enable for the current cycle
ALUResult  in  32  byte address of the access
WriteData  in  32  store data
read_data  out  32  load data, combinational from ALUResult
gpio_out  out  32  GPIO output register contents
timer_irq  out  1  timer interrupt, equals FLAG & IRQ_EN
access_fault  out  1  combinational; misaligned or unmapped address

Behaviour:
- Reset: reset low asynchronously clears GPIO_OUT, CYCLE_CNT, TIMER_CNT, TIMER_CMP and CTRL to 0, so gpio_out=0 and timer_irq=0. RAM contents are not reset; reading a word before it is written returns an undefined value.
- Decode:
  - RAM hit when ALUResult < 4*DEPTH_WORDS.
  - MMIO hit when MMIO_BASE <= ALUResult < MMIO_BASE+0x20.
  - Anything else is unmapped.
- Fault and read-back rules:
  - access_fault=1 when ALUResult[1:0]!=0 or the address is unmapped. A faulting access returns read_data=0 and any write is suppressed. access_fault is evaluated regardless of MemWrite.
  - Unused MMIO slots (offsets 0x14-0x1C) read 0, ignore writes and raise no fault.
- MMIO map (word offsets from MMIO_BASE):
  - 0x00 GPIO_OUT: read/write.
  - 0x04 CYCLE_CNT: read-only. Increments by 1 every cycle out of reset and wraps 0xFFFF_FFFF -> 0. Writes are ignored.
  - 0x08 TIMER_CMP: read/write.
  - 0x0C CTRL:
    - bit0 EN, bit1 AUTO, bit2 IRQ_EN: read/write.
    - bit3 FLAG: write-1-to-clear, writing 0 has no effect.
    - bits31:4 read 0.
  - 0x10 TIMER_CNT: read/write.
- Latency: loads are combinational (0 cycles). A store is visible to a read in the cycle after its clock edge. Read-during-write in the same cycle returns the old value.
- Timer, evaluated each edge with EN=1:
  - match = (TIMER_CNT == TIMER_CMP).
  - Next TIMER_CNT = 0 if match and AUTO, otherwise TIMER_CNT+1 (wraps at 2^32).
  - FLAG is set at the edge following a match cycle.
  - With EN=0, TIMER_CNT holds and no match is detected.
- Priorities:
  - A software write to TIMER_CNT overrides the increment/reload in that cycle.
  - FLAG set (match) and W1C clear in the same cycle: set wins, FLAG=1.
  - A CTRL write takes effect for the next cycle; the current cycle's match uses the old EN.
  - CMP=0, CNT=0, EN=1: match on the first enabled cycle.
- timer_irq is registered-state derived, with no combinational path from inputs: timer_irq = FLAG & IRQ_EN.
- Reset asserted mid-operation: all registers clear immediately. CYCLE_CNT restarts at 0 on the first edge after reset release, reaching 1 after that edge.

Test Plan:
- Release reset, no stores -> gpio_out=0, timer_irq=0. After 5 edges, a read of 0x1004 returns 5; read 0x100C returns 0.
- Store 0xDEADBEEF to 0x0000_0010, then read 0x10 next cycle -> 0xDEADBEEF. Same-cycle read during the store -> old value. Read 0x0000_0100 (DEPTH=64) -> read_data=0, access_fault=1.
- Store to 0x0000_0012 (misaligned) -> access_fault=1 and RAM word 0x10 unchanged. Store 0x55 to 0x1000 -> gpio_out=0x55 after the edge. Store to 0x1004 -> CYCLE_CNT is unaffected.
- CMP=3, CTRL=0x7 (EN|AUTO|IRQ_EN) -> TIMER_CNT sequence 0,1,2,3,0,1. FLAG and timer_irq rise at the edge after CNT=3. Writing CTRL=0xF clears FLAG.
- CMP=2, CTRL=0x1 (no AUTO) -> CNT continues 3,4,...; FLAG=1 but timer_irq=0. A W1C in the same cycle as a match -> FLAG remains 1.
- Timer running with CNT=7, assert reset for 1 cycle -> all MMIO registers read 0 and gpio_out=0 immediately. Write TIMER_CNT=0xFFFF_FFFF with EN=1 -> wraps to 0 next cycle.

Source files
------------

// File: rtl/data_mem_mmio_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_mmio_if
// Description : Core-to-data-memory access bus. The core drives the store
//               enable, byte address and store data. The memory returns
//               combinational load data and an access-fault indication.
// Revision    : 1.0  initial release
// ============================================================================
interface data_mem_mmio_if;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] read_data;
    logic        access_fault;

    // Memory side
    modport slave (
        input  MemWrite,
        input  ALUResult,
        input  WriteData,
        output read_data,
        output access_fault
    );

    // Core side
    modport master (
        output MemWrite,
        output ALUResult,
        output WriteData,
        input  read_data,
        input  access_fault
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_mmio.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_mmio
// Description : Data memory for a single-cycle core. Word-addressed RAM plus
//               an 8-slot MMIO window holding a GPIO output register, a
//               free-running cycle counter and a compare timer with an
//               interrupt. Loads are combinational. Stores and all register
//               updates happen on the rising clock edge.
// Revision    : 1.0  initial release
// ============================================================================
module data_mem_mmio #(
    parameter int          DEPTH_WORDS = 64,
    // Must be aligned to 32 bytes. The slot select uses the address bits directly.
    parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
    input  wire logic        clk,
    input  wire logic        reset,      // asynchronous, active-low
    data_mem_mmio_if.slave   bus,
    output logic [31:0]      gpio_out,
    output logic             timer_irq
);

    localparam int          c_IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] c_RAM_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [31:0] c_MMIO_END  = MMIO_BASE + 32'h0000_0020;

    localparam logic [2:0]  c_SLOT_GPIO  = 3'd0;
    localparam logic [2:0]  c_SLOT_CYCLE = 3'd1;
    localparam logic [2:0]  c_SLOT_CMP   = 3'd2;
    localparam logic [2:0]  c_SLOT_CTRL  = 3'd3;
    localparam logic [2:0]  c_SLOT_CNT   = 3'd4;

    // Storage
    logic [31:0] r_ram [0:DEPTH_WORDS-1];
    logic [31:0] r_gpio;
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_timer_cnt;
    logic [31:0] r_timer_cmp;
    logic        r_en;
    logic        r_auto;
    logic        r_irq_en;
    logic        r_flag;

    // Decode
    logic               w_ram_hit;
    logic               w_mmio_hit;
    logic               w_fault;
    logic               w_wr_ok;
    logic               w_ram_we;
    logic               w_mmio_we;
    logic [2:0]         w_slot;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_match;
    logic               w_wr_gpio;
    logic               w_wr_cmp;
    logic               w_wr_ctrl;
    logic               w_wr_cnt;

    assign w_ram_hit  = (bus.ALUResult < c_RAM_BYTES);
    assign w_mmio_hit = (bus.ALUResult >= MMIO_BASE) && (bus.ALUResult < c_MMIO_END);
    assign w_fault    = (bus.ALUResult[1:0] != 2'b00) || !(w_ram_hit || w_mmio_hit);
    assign w_wr_ok    = bus.MemWrite && !w_fault;
    assign w_ram_we   = w_wr_ok && w_ram_hit;
    assign w_mmio_we  = w_wr_ok && w_mmio_hit;
    assign w_slot     = bus.ALUResult[4:2];
    assign w_idx      = bus.ALUResult[c_IDX_W+1:2];

    assign w_wr_gpio  = w_mmio_we && (w_slot == c_SLOT_GPIO);
    assign w_wr_cmp   = w_mmio_we && (w_slot == c_SLOT_CMP);
    assign w_wr_ctrl  = w_mmio_we && (w_slot == c_SLOT_CTRL);
    assign w_wr_cnt   = w_mmio_we && (w_slot == c_SLOT_CNT);

    // The match is qualified by the current EN, so a CTRL write only affects later cycles
    assign w_match    = r_en && (r_timer_cnt == r_timer_cmp);

    assign bus.access_fault = w_fault;
    assign gpio_out         = r_gpio;
    assign timer_irq        = r_flag & r_irq_en;

    // RAM write port. The contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_idx] <= bus.WriteData;
        end
    end

    // Free-running cycle counter. It wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle_cnt <= 32'd0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    // Software-written registers: GPIO, compare value and control bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gpio      <= 32'd0;
            r_timer_cmp <= 32'd0;
            r_en        <= 1'b0;
            r_auto      <= 1'b0;
            r_irq_en    <= 1'b0;
        end else begin
            if (w_wr_gpio) begin
                r_gpio <= bus.WriteData;
            end
            if (w_wr_cmp) begin
                r_timer_cmp <= bus.WriteData;
            end
            if (w_wr_ctrl) begin
                r_en     <= bus.WriteData[0];
                r_auto   <= bus.WriteData[1];
                r_irq_en <= bus.WriteData[2];
            end
        end
    end

    // Timer count. A software write wins over the increment or auto-reload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer_cnt <= 32'd0;
        end else if (w_wr_cnt) begin
            r_timer_cnt <= bus.WriteData;
        end else if (r_en) begin
            r_timer_cnt <= (w_match && r_auto) ? 32'd0 : (r_timer_cnt + 32'd1);
        end
    end

    // Match flag. It is sticky and write-1-to-clear. A set in the same cycle wins over a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flag <= 1'b0;
        end else if (w_match) begin
            r_flag <= 1'b1;
        end else if (w_wr_ctrl && bus.WriteData[3]) begin
            r_flag <= 1'b0;
        end
    end

    // Combinational load path. Faults and unused MMIO slots return zero.
    always_comb begin
        bus.read_data = 32'd0;
        if (!w_fault) begin
            if (w_ram_hit) begin
                bus.read_data = r_ram[w_idx];
            end else begin
                case (w_slot)
                    c_SLOT_GPIO:  bus.read_data = r_gpio;
                    c_SLOT_CYCLE: bus.read_data = r_cycle_cnt;
                    c_SLOT_CMP:   bus.read_data = r_timer_cmp;
                    c_SLOT_CTRL:  bus.read_data = {28'd0, r_flag, r_irq_en, r_auto, r_en};
                    c_SLOT_CNT:   bus.read_data = r_timer_cnt;
                    default:      bus.read_data = 32'd0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_mmio.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_mmio
// Description : Self-checking bench for data_mem_mmio. Directed steps are
//               followed by a randomized access phase. Every access is
//               compared against a behavioural memory/timer model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_data_mem_mmio;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] gpio_out;
    logic        timer_irq;

    data_mem_mmio_if bus ();

    data_mem_mmio #(
        .DEPTH_WORDS (64),
        .MMIO_BASE   (32'h0000_1000)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [31:0] m_ram   [0:63];
    bit          m_valid [0:63];
    logic [31:0] m_gpio, m_cycle, m_cnt, m_cmp;
    bit          m_en, m_auto, m_irqen, m_flag;

    logic [31:0] rd;
    int          seq_auto [6] = '{0, 1, 2, 3, 0, 1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic bit m_fault(input logic [31:0] a);
        bit mapped;
        mapped = (a < 32'd256) || ((a >= 32'h1000) && (a < 32'h1020));
        return (a[1:0] != 2'b00) || !mapped;
    endfunction

    task automatic model_reset();
        m_gpio = 0; m_cycle = 0; m_cnt = 0; m_cmp = 0;
        m_en = 0; m_auto = 0; m_irqen = 0; m_flag = 0;
    endtask

    // Value a load from address a should return. defd is cleared for a never-written RAM word.
    task automatic m_read(input logic [31:0] a, output logic [31:0] v, output bit defd);
        defd = 1'b1;
        v    = 32'd0;
        if (!m_fault(a)) begin
            if (a < 32'd256) begin
                defd = m_valid[a[7:2]];
                v    = m_ram[a[7:2]];
            end else begin
                case (a[4:0])
                    5'h00:   v = m_gpio;
                    5'h04:   v = m_cycle;
                    5'h08:   v = m_cmp;
                    5'h0C:   v = {28'd0, m_flag, m_irqen, m_auto, m_en};
                    5'h10:   v = m_cnt;
                    default: v = 32'd0;
                endcase
            end
        end
    endtask

    // Advance the model by one clock edge for the access presented in that cycle
    task automatic m_clock(input bit we, input logic [31:0] a, input logic [31:0] d);
        bit          ok, hit, clr;
        logic [31:0] nxt;
        ok  = we && !m_fault(a);
        hit = m_en && (m_cnt == m_cmp);
        clr = 1'b0;
        nxt = m_cnt;
        if (m_en) nxt = (hit && m_auto) ? 32'd0 : m_cnt + 32'd1;
        if (ok && a < 32'd256) begin
            m_ram[a[7:2]]   = d;
            m_valid[a[7:2]] = 1'b1;
        end else if (ok) begin
            case (a[4:0])
                5'h00: m_gpio = d;
                5'h08: m_cmp  = d;
                5'h0C: begin
                    m_en = d[0]; m_auto = d[1]; m_irqen = d[2]; clr = d[3];
                end
                5'h10: nxt = d;
                default: ;
            endcase
        end
        if (hit)      m_flag = 1'b1;
        else if (clr) m_flag = 1'b0;
        m_cnt   = nxt;
        m_cycle = m_cycle + 32'd1;
    endtask

    // One bus cycle: check the load before the edge, then check the registered outputs after it
    task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] pre_rd);
        logic [31:0] ev;
        bit          defd;
        bus.MemWrite  = we;
        bus.ALUResult = a;
        bus.WriteData = d;
        @(negedge clk);
        m_read(a, ev, defd);
        check("fault", 32'(bus.access_fault), 32'(m_fault(a)));
        if (defd) check("rdata", bus.read_data, ev);
        pre_rd = bus.read_data;
        @(posedge clk);
        m_clock(we, a, d);
        #1;
        bus.MemWrite = 1'b0;
        check("gpio", gpio_out, m_gpio);
        check("irq", 32'(timer_irq), 32'(m_flag & m_irqen));
    endtask

    task automatic peek(input logic [31:0] a, input string tag, input logic [31:0] exp);
        bus.MemWrite  = 1'b0;
        bus.ALUResult = a;
        #1;
        check(tag, bus.read_data, exp);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_ram[i]   = 32'd0;
        end
        model_reset();
        bus.MemWrite  = 1'b0;
        bus.ALUResult = 32'd0;
        bus.WriteData = 32'd0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("rst_gpio0", gpio_out, 32'd0);
        check("rst_irq0", 32'(timer_irq), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Cycle counter after five edges
        for (int i = 0; i < 5; i++) access(1'b0, 32'h1004, 32'd0, rd);
        peek(32'h1004, "cyc5", 32'd5);
        peek(32'h100C, "ctrl0", 32'd0);

        // RAM store, read-during-write, and an out-of-range load
        access(1'b1, 32'h10, 32'hDEAD_BEEF, rd);
        peek(32'h10, "ram_wr", 32'hDEAD_BEEF);
        access(1'b1, 32'h10, 32'h1234_5678, rd);
        check("rdw_old", rd, 32'hDEAD_BEEF);
        peek(32'h10, "ram_wr2", 32'h1234_5678);
        access(1'b0, 32'h100, 32'd0, rd);
        check("oob_rd", rd, 32'd0);
        bus.ALUResult = 32'h100;
        #1 check("oob_fault", 32'(bus.access_fault), 32'd1);

        // Misaligned store is dropped; GPIO store; CYCLE_CNT ignores stores
        access(1'b1, 32'h12, 32'hAAAA_AAAA, rd);
        peek(32'h10, "misal_keep", 32'h1234_5678);
        access(1'b1, 32'h1000, 32'h55, rd);
        check("gpio55", gpio_out, 32'h55);
        access(1'b1, 32'h1004, 32'hFFFF_0000, rd);
        peek(32'h1004, "cyc_ro", 32'd11);

        // Auto-reload timer with CMP=3
        access(1'b1, 32'h1008, 32'd3, rd);
        access(1'b1, 32'h1010, 32'd0, rd);
        access(1'b1, 32'h100C, 32'h7, rd);
        for (int i = 0; i < 6; i++) begin
            access(1'b0, 32'h1010, 32'd0, rd);
            check("tseq_auto", rd, 32'(seq_auto[i]));
            check("tirq_auto", 32'(timer_irq), 32'(i >= 3));
        end
        access(1'b1, 32'h100C, 32'hF, rd);
        check("w1c_irq", 32'(timer_irq), 32'd0);
        peek(32'h100C, "w1c_ctrl", 32'h7);

        // One-shot compare with CMP=2, no auto-reload and no interrupt enable
        access(1'b1, 32'h100C, 32'h8, rd);
        access(1'b1, 32'h1010, 32'd0, rd);
        access(1'b1, 32'h1008, 32'd2, rd);
        access(1'b1, 32'h100C, 32'h1, rd);
        for (int i = 0; i < 5; i++) begin
            access(1'b0, 32'h1010, 32'd0, rd);
            check("tseq_free", rd, 32'(i));
        end
        peek(32'h100C, "flag_noirq", 32'h9);
        check("noirq", 32'(timer_irq), 32'd0);
        access(1'b1, 32'h1010, 32'd1, rd);
        access(1'b0, 32'h1010, 32'd0, rd);
        check("cnt_sw", rd, 32'd1);
        access(1'b1, 32'h100C, 32'h9, rd);      // W1C in the same cycle as the CNT=2 match
        peek(32'h100C, "w1c_vs_set", 32'h9);
        peek(32'h1010, "cnt_after", 32'd3);

        // Reset in the middle of operation
        access(1'b1, 32'h1010, 32'd7, rd);
        reset = 1'b0;
        #1 check("rst_gpio", gpio_out, 32'd0);
        peek(32'h1010, "rst_cnt", 32'd0);
        peek(32'h1000, "rst_gpio_rd", 32'd0);
        peek(32'h100C, "rst_ctrl", 32'd0);
        peek(32'h1004, "rst_cyc", 32'd0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        access(1'b0, 32'h1004, 32'd0, rd);
        peek(32'h1004, "cyc_restart", 32'd1);

        // Counter wrap, then CMP=0 matches at CNT=0
        access(1'b1, 32'h100C, 32'h1, rd);
        access(1'b1, 32'h1010, 32'hFFFF_FFFF, rd);
        access(1'b0, 32'h1010, 32'd0, rd);
        check("cnt_max", rd, 32'hFFFF_FFFF);
        peek(32'h1010, "cnt_wrap", 32'd0);
        access(1'b0, 32'h100C, 32'd0, rd);
        peek(32'h100C, "cmp0_match", 32'h9);

        // Randomized accesses checked against the model
        for (int n = 0; n < 400; n++) begin
            int unsigned k;
            logic [31:0] a, d;
            bit          we;
            k  = $urandom_range(0, 9);
            d  = $urandom;
            we = 1'($urandom_range(0, 1));
            case (k)
                0, 1, 2, 3: a = 32'($urandom_range(0, 63)) * 4;
                4:          a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
                5, 6, 7: begin
                    a = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
                    if (a == 32'h1008 || a == 32'h1010) d = 32'($urandom_range(0, 5));
                    if (a == 32'h100C) d = 32'($urandom_range(0, 15));
                end
                8:  a = ($urandom_range(0, 1) == 1) ? 32'h1020 + 32'($urandom_range(0, 100)) * 4
                                                    : 32'h100 + 32'($urandom_range(0, 900)) * 4;
                default: a = 32'h1000 + 32'($urandom_range(0, 31));
            endcase
            access(we, a, d, rd);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
